crank_cam_gen: RTL

CRANK_CAM_GEN -- requirements
Module: crank_cam_gen

---
 rtl/ccg_pkg.sv | 10 +
 rtl/ccg_ramp.sv | 34 +++
 rtl/crank_cam_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ccg_pkg.sv
// Shared defaults and constants for the crank/cam wheel generator.
// Latency/backpressure: none (constants only).
package ccg_pkg;

    localparam int TEETH_TOTAL_DEF   = 60;
    localparam int TEETH_MISSING_DEF = 2;
    localparam int PER_W_DEF         = 16;
    localparam int PER_MIN           = 2;

endpackage

// File: rtl/ccg_ramp.sv
// Per-revolution tooth-period slew: steps per_cur toward the clamped target without overshoot.
// Latency: combinational; backpressure: none.
module ccg_ramp
    import ccg_pkg::*;
#(
    parameter int PER_W = PER_W_DEF
) (
    input  logic [PER_W-1:0] per_cur_i,
    input  logic [PER_W-1:0] per_target_i,
    input  logic [PER_W-1:0] ramp_step_i,
    input  logic             update_i,
    output logic [PER_W-1:0] per_tgt_o,
    output logic [PER_W-1:0] per_nxt_o
);

    localparam logic [PER_W-1:0] PMIN = PER_W'(PER_MIN);

    logic [PER_W-1:0] diff;
    logic [PER_W-1:0] step;
    logic             rising;

    always_comb begin
        per_tgt_o = (per_target_i < PMIN) ? PMIN : per_target_i;
        rising    = (per_tgt_o >= per_cur_i);
        diff      = rising ? (per_tgt_o - per_cur_i) : (per_cur_i - per_tgt_o);
        // A zero step means "no slew limit", which collapses to taking the whole difference.
        step      = ((ramp_step_i == '0) || (ramp_step_i > diff)) ? diff : ramp_step_i;
        per_nxt_o = per_cur_i;
        if (update_i) begin
            per_nxt_o = rising ? (per_cur_i + step) : (per_cur_i - step);
        end
    end

endmodule

// File: rtl/crank_cam_gen.sv
// Crank (N-M missing-tooth) and cam waveform generator with per-revolution period ramp.
// Latency: outputs registered, aligned with tooth/tick state; backpressure: enable=0 freezes everything.
module crank_cam_gen
    import ccg_pkg::*;
#(
    parameter int TEETH_TOTAL   = TEETH_TOTAL_DEF,
    parameter int TEETH_MISSING = TEETH_MISSING_DEF,
    parameter int PER_W         = PER_W_DEF,
    parameter int TW            = $clog2(TEETH_TOTAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PER_W-1:0] per_target,
    input  logic [PER_W-1:0] ramp_step,
    input  logic [TW-1:0]    cam_start,
    input  logic [TW-1:0]    cam_end,
    output logic             vr,
    output logic             cam,
    output logic [TW-1:0]    tooth_idx,
    output logic             gap,
    output logic             rev_pulse,
    output logic             phase
);

    localparam logic [TW-1:0]    IDX_LAST = TW'(TEETH_TOTAL - 1);
    localparam logic [TW-1:0]    IDX_GAP  = TW'(TEETH_TOTAL - TEETH_MISSING);
    localparam logic [TW-1:0]    IDX_RST  = TW'(TEETH_TOTAL - TEETH_MISSING - 5);
    localparam logic [PER_W-1:0] PMIN     = PER_W'(PER_MIN);

    logic [PER_W-1:0] tick_q, tick_d;
    logic [PER_W-1:0] per_cur_q, per_cur_d;
    logic [PER_W-1:0] per_eff_q, per_eff_d;
    logic [TW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    cs_q, cs_d;
    logic [TW-1:0]    ce_q, ce_d;
    logic             phase_q, phase_d;
    logic             start_q, start_d;
    logic             vr_q, vr_d;
    logic             cam_q, cam_d;
    logic             gap_q, gap_d;
    logic             rev_q, rev_d;

    logic             tooth_end;
    logic             rev_wrap;
    logic [PER_W-1:0] per_tgt;
    logic [PER_W-1:0] per_ramp;

    function automatic logic in_win(logic [TW-1:0] i, logic [TW-1:0] s, logic [TW-1:0] e);
        logic r;
        r = 1'b0;
        if (s < e) begin
            r = (i >= s) && (i < e);
        end else if (s > e) begin
            r = (i >= s) || (i < e);
        end
        return r;
    endfunction

    assign tooth_end = (tick_q == (per_eff_q - PER_W'(1)));
    assign rev_wrap  = tooth_end && (idx_q == IDX_LAST);

    ccg_ramp #(.PER_W(PER_W)) u_ramp (
        .per_cur_i    (per_cur_q),
        .per_target_i (per_target),
        .ramp_step_i  (ramp_step),
        .update_i     (rev_wrap),
        .per_tgt_o    (per_tgt),
        .per_nxt_o    (per_ramp)
    );

    always_comb begin
        tick_d    = tick_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        per_cur_d = per_cur_q;
        per_eff_d = per_eff_q;
        cs_d      = cs_q;
        ce_d      = ce_q;
        start_d   = start_q;
        vr_d      = vr_q;
        cam_d     = cam_q;
        gap_d     = gap_q;
        rev_d     = 1'b0;
        if (enable) begin
            // First enabled clock after reset opens the pre-gap tooth with a fresh target sample.
            if (start_q) begin
                start_d   = 1'b0;
                tick_d    = '0;
                per_cur_d = per_tgt;
                per_eff_d = per_tgt;
                cs_d      = cam_start;
                ce_d      = cam_end;
            end else if (tooth_end) begin
                tick_d = '0;
                cs_d   = cam_start;
                ce_d   = cam_end;
                if (idx_q == IDX_LAST) begin
                    idx_d     = '0;
                    phase_d   = ~phase_q;
                    per_cur_d = per_ramp;
                    per_eff_d = per_ramp;
                    rev_d     = 1'b1;
                end else begin
                    idx_d     = idx_q + TW'(1);
                    per_eff_d = per_cur_q;
                end
            end else begin
                tick_d = tick_q + PER_W'(1);
            end
            gap_d = (idx_d >= IDX_GAP);
            vr_d  = !gap_d && (tick_d >= (per_eff_d >> 1));
            cam_d = phase_d && in_win(idx_d, cs_d, ce_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q    <= '0;
            idx_q     <= IDX_RST;
            phase_q   <= 1'b0;
            per_cur_q <= PMIN;
            per_eff_q <= PMIN;
            cs_q      <= '0;
            ce_q      <= '0;
            start_q   <= 1'b1;
            vr_q      <= 1'b0;
            cam_q     <= 1'b0;
            gap_q     <= 1'b0;
            rev_q     <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            per_cur_q <= per_cur_d;
            per_eff_q <= per_eff_d;
            cs_q      <= cs_d;
            ce_q      <= ce_d;
            start_q   <= start_d;
            vr_q      <= vr_d;
            cam_q     <= cam_d;
            gap_q     <= gap_d;
            rev_q     <= rev_d;
        end
    end

    assign vr        = vr_q;
    assign cam       = cam_q;
    assign tooth_idx = idx_q;
    assign gap       = gap_q;
    assign rev_pulse = rev_q;
    assign phase     = phase_q;

endmodule
